pwm_carrier_sched: RTL and testbench
====================================

# pwm_carrier_sched

Carrier generator and duty-cycle update scheduler for the inverter PWM legs. Produces the shared 8-bit symmetric triangle carrier and its clock-enable strobe, and double-buffers per-leg duty commands so new values reach the comparators only at carrier valleys (optionally also peaks). Sits between the register/control interface and the per-leg 8-bit carrier-vs-duty comparators.

## Interface
- N_LEGS, 6, number of PWM legs scheduled
- LEG_W, 3, width of leg index; must satisfy 2^LEG_W >= N_LEGS
- UPDATE_BOTH, 0, 0 = load at valley only; 1 = load at valley and peak

- sys_clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; low = carrier stopped, all legs forced off
- divider  in  8  prescaler; carrier step every divider+1 clocks
- wr_en  in  1  single-cycle duty write strobe
- wr_leg  in  LEG_W  leg index for write
- wr_duty  in  8  new duty (0 = always off, 255 = always on)
- carrier  out  8  triangle carrier to comparators
- sys_ce  out  1  one-cycle strobe, high on each carrier step
- duty_active  out  8*N_LEGS  active duties, leg k at bits [8k+7:8k]
- pending  out  N_LEGS  shadow written but not yet loaded
- valley_pulse  out  1  one cycle when carrier enters 0
- peak_pulse  out  1  one cycle when carrier enters 255

## Operation
- Prescaler: counter 0..div_l; tick when count == div_l, then count -> 0. div_l latched from divider at reset-release and on every tick; mid-interval divider changes apply after the current interval.
- Carrier: on tick, up: 0->1->...->255, at 255 direction -> down; down: 255->254->...->0, at 0 direction -> up. Period 510 ticks = 510*(divider+1) clocks. Values 0 and 255 each held for one tick.
- sys_ce registered, high the cycle carrier holds its new value.
- Shadow regs: wr_en with wr_leg < N_LEGS writes shadow[wr_leg], sets pending[wr_leg]. wr_leg >= N_LEGS ignored, no flag change. Writes accepted every cycle; last write before load wins.
- Load event: edge where carrier register becomes 0 (and becomes 255 if UPDATE_BOTH=1). On that edge duty_active[k] <= shadow[k] for all k, pending cleared.
- Write on a load-event cycle: goes to shadow, pending set; not part of this load; loads at next event.
- valley_pulse/peak_pulse asserted on the same edge carrier enters 0/255 (registered).
- en low (sampled synchronously): next edge prescaler -> 0, carrier -> 0, direction up, sys_ce -> 0, duty_active -> all 0, pulses 0. Shadow and pending retained; writes still accepted.
- en rising: first enabled edge loads all shadows into duty_active, clears pending, asserts valley_pulse; prescaler starts from 0.
- Unloaded legs: duty_active is exactly the last loaded shadow; shadow reset value 0.

## Timing
- Reset (async, rst_n low): carrier 0, direction up, prescaler 0, div_l 0, sys_ce 0, duty_active 0, shadow 0, pending 0, both pulses 0. Reset mid-period discards everything immediately.
- After reset release with en high, divider=D: first tick at clock D+1 after release (counts 0..D).
- Write-to-pending latency 1 clock. Write-to-duty_active latency: until next load event, max one carrier half-period (UPDATE_BOTH=1) or period (0).
- Load, carrier update, and pulse are the same clock edge; comparators see a new duty together with carrier 0 (or 255).
- All outputs registered; no combinational input-to-output paths.

## Test plan
- divider=0, en=1 from reset: carrier rises 0..255 then falls 255..0; valley_pulse every 510 clocks, peak_pulse 255 clocks after valley; sys_ce high every clock.
- divider=3: sys_ce every 4th clock, valley period 2040 clocks; change divider to 1 mid-interval -> current interval completes in 4 clocks, next intervals 2.
- UPDATE_BOTH=0: write leg 2 = 128 at carrier 100 (rising) -> pending[2]=1 next clock; duty_active[2] unchanged through peak; becomes 128 and pending clears on edge carrier enters 0.
- Write leg 0 = 200 on exact load-event cycle -> duty_active[0] keeps old value, pending[0]=1, loads at next event; write leg 7 (N_LEGS=6) -> no effect.
- UPDATE_BOTH=1: write leg 1 = 50 while falling -> loads at valley; write 60 while rising -> loads at peak.
- en low mid-period at carrier 180 -> next clock carrier 0, duty_active all 0; write leg 3 = 90 while disabled; en high -> first edge duty_active[3]=90, valley_pulse=1. rst_n low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/pwm_carrier_sched.sv
// Symmetric 8-bit triangle carrier with prescaled step strobe and valley/peak-synchronous duty double-buffering.
// Latency: write->pending 1 clk, write->duty_active at next load event; no backpressure, writes accepted every cycle.
module pwm_carrier_sched #(
   parameter int N_LEGS      = 6,
   parameter int LEG_W       = 3,
   parameter bit UPDATE_BOTH = 1'b0
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [7:0]            divider,
   input  logic                  wr_en,
   input  logic [LEG_W-1:0]      wr_leg,
   input  logic [7:0]            wr_duty,
   output logic [7:0]            carrier,
   output logic                  sys_ce,
   output logic [8*N_LEGS-1:0]   duty_active,
   output logic [N_LEGS-1:0]     pending,
   output logic                  valley_pulse,
   output logic                  peak_pulse
);

   logic [7:0]              presc_q;
   logic [7:0]              div_l_q;
   logic                    armed_q;
   logic                    en_q;
   logic                    dir_up_q;
   logic [N_LEGS-1:0][7:0]  shadow_q;
   logic [N_LEGS-1:0][7:0]  duty_q;

   logic [7:0]              div_eff;
   logic                    restart;
   logic                    tick;
   logic [7:0]              car_nxt;
   logic                    dir_nxt;
   logic                    at_valley;
   logic                    at_peak;
   logic                    load;
   logic [N_LEGS-1:0]       wr_hit;

   // Until the first enabled edge has latched it, the live divider governs the interval.
   assign div_eff = armed_q ? div_l_q : divider;
   assign restart = en && !en_q;
   assign tick    = en && !restart && (presc_q == div_eff);

   always_comb begin
      car_nxt = carrier;
      dir_nxt = dir_up_q;
      if (tick) begin
         if (dir_up_q) begin
            car_nxt = carrier + 8'd1;
            if (carrier == 8'd254) dir_nxt = 1'b0;
         end else begin
            car_nxt = carrier - 8'd1;
            if (carrier == 8'd1) dir_nxt = 1'b1;
         end
      end
   end

   assign at_valley = tick && (car_nxt == 8'd0);
   assign at_peak   = tick && (car_nxt == 8'd255);
   assign load      = restart || at_valley || (UPDATE_BOTH && at_peak);

   always_comb begin
      wr_hit = '0;
      for (int k = 0; k < N_LEGS; k++) begin
         wr_hit[k] = wr_en && (wr_leg == LEG_W'(k));
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q      <= 8'd0;
         div_l_q      <= 8'd0;
         armed_q      <= 1'b0;
         en_q         <= 1'b1;
         carrier      <= 8'd0;
         dir_up_q     <= 1'b1;
         sys_ce       <= 1'b0;
         valley_pulse <= 1'b0;
         peak_pulse   <= 1'b0;
      end else begin
         en_q <= en;
         if (!en || restart) begin
            presc_q      <= 8'd0;
            div_l_q      <= divider;
            armed_q      <= 1'b0;
            carrier      <= 8'd0;
            dir_up_q     <= 1'b1;
            sys_ce       <= 1'b0;
            valley_pulse <= restart;
            peak_pulse   <= 1'b0;
         end else begin
            armed_q <= 1'b1;
            if (tick) begin
               presc_q <= 8'd0;
               div_l_q <= divider;
            end else begin
               presc_q <= presc_q + 8'd1;
               if (!armed_q) div_l_q <= divider;
            end
            carrier      <= car_nxt;
            dir_up_q     <= dir_nxt;
            sys_ce       <= tick;
            valley_pulse <= at_valley;
            peak_pulse   <= at_peak;
         end
      end
   end

   // A write on a load edge lands in the shadow only; the active copy takes the pre-write shadow.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         duty_q   <= '0;
         pending  <= '0;
      end else begin
         for (int k = 0; k < N_LEGS; k++) begin
            if (wr_hit[k]) shadow_q[k] <= wr_duty;
         end
         if (!en)       duty_q <= '0;
         else if (load) duty_q <= shadow_q;
         pending <= (load ? '0 : pending) | wr_hit;
      end
   end

   assign duty_active = duty_q;

endmodule

// File: tb/tb_pwm_carrier_sched.sv
// Directed bench for pwm_carrier_sched: valley-only and valley+peak instances share one stimulus stream.
module tb_pwm_carrier_sched;

   logic        sys_clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [7:0]  divider;
   logic        wr_en;
   logic [2:0]  wr_leg;
   logic [7:0]  wr_duty;

   logic [7:0]  carrier_a, carrier_b;
   logic        ce_a, ce_b;
   logic [47:0] duty_a, duty_b;
   logic [5:0]  pending_a, pending_b;
   logic        valley_a, valley_b;
   logic        peak_a, peak_b;

   int n_chk  = 0;
   int n_pass = 0;
   int edge_n = 0;

   always #10 sys_clk = ~sys_clk;

   pwm_carrier_sched #(.N_LEGS(6), .LEG_W(3), .UPDATE_BOTH(1'b0)) u_dut_a (
      .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .divider(divider),
      .wr_en(wr_en), .wr_leg(wr_leg), .wr_duty(wr_duty),
      .carrier(carrier_a), .sys_ce(ce_a), .duty_active(duty_a), .pending(pending_a),
      .valley_pulse(valley_a), .peak_pulse(peak_a)
   );

   pwm_carrier_sched #(.N_LEGS(6), .LEG_W(3), .UPDATE_BOTH(1'b1)) u_dut_b (
      .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .divider(divider),
      .wr_en(wr_en), .wr_leg(wr_leg), .wr_duty(wr_duty),
      .carrier(carrier_b), .sys_ce(ce_b), .duty_active(duty_b), .pending(pending_b),
      .valley_pulse(valley_b), .peak_pulse(peak_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] leg(input logic [47:0] v, input int k);
      return v[8*k +: 8];
   endfunction

   task automatic cyc();
      @(posedge sys_clk);
      #1;
      edge_n++;
   endtask

   task automatic run_to(input int n);
      while (edge_n < n) cyc();
   endtask

   task automatic wr(input logic [2:0] l, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_leg  = l;
      wr_duty = d;
      cyc();
      wr_en   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      int ce_cnt, v_cnt, p_cnt;
      logic [11:0] ce_got;
      logic [11:0] ce_exp;
      ce_exp  = 12'b1010_1000_1000;
      rst_n   = 1'b0;
      en      = 1'b1;
      divider = 8'd0;
      wr_en   = 1'b0;
      wr_leg  = 3'd0;
      wr_duty = 8'd0;
      #15;
      chk("rst_carrier", carrier_a, 0);
      chk("rst_sys_ce", ce_a, 0);
      chk("rst_duty", duty_a, 0);
      chk("rst_pending", pending_a, 0);
      chk("rst_pulses", {valley_a, peak_a}, 0);

      @(posedge sys_clk);
      #1;
      rst_n = 1'b1;
      cyc();
      chk("first_tick_carrier", carrier_a, 1);
      chk("first_tick_ce", ce_a, 1);

      ce_cnt = 0; v_cnt = 0; p_cnt = 0;
      while (edge_n < 510) begin
         cyc();
         ce_cnt += int'(ce_a);
         v_cnt  += int'(valley_a);
         p_cnt  += int'(peak_a);
         if (edge_n == 255) begin
            chk("peak_carrier", carrier_a, 255);
            chk("peak_pulse", peak_a, 1);
         end
         if (edge_n == 256) chk("fall_carrier", carrier_a, 254);
         if (edge_n == 510) begin
            chk("valley_carrier", carrier_a, 0);
            chk("valley_pulse", valley_a, 1);
         end
      end
      chk("ce_every_clock", ce_cnt, 509);
      chk("valley_count", v_cnt, 1);
      chk("peak_count", p_cnt, 1);

      run_to(610);
      chk("carrier_100", carrier_a, 100);
      wr(3'd2, 8'd128);
      chk("pend_leg2", pending_a, 6'b000100);
      chk("leg2_unloaded", leg(duty_a, 2), 0);
      run_to(764);
      chk("b_leg2_prepeak", leg(duty_b, 2), 0);
      cyc();
      chk("b_leg2_peak", leg(duty_b, 2), 128);
      chk("b_pend_peak", pending_b, 0);
      chk("a_leg2_peak", leg(duty_a, 2), 0);
      chk("a_pend_peak", pending_a, 6'b000100);
      run_to(1019);
      chk("a_leg2_prevalley", leg(duty_a, 2), 0);
      cyc();
      chk("a_leg2_valley", leg(duty_a, 2), 128);
      chk("a_pend_valley", pending_a, 0);
      chk("a_valley_pulse", valley_a, 1);

      run_to(1529);
      wr(3'd0, 8'd200);
      chk("loadcyc_leg0", leg(duty_a, 0), 0);
      chk("loadcyc_pend", pending_a, 6'b000001);
      run_to(1599);
      wr(3'd7, 8'd77);
      chk("leg7_pend", pending_a, 6'b000001);
      run_to(1784);
      chk("b_leg0_prepeak", leg(duty_b, 0), 0);
      cyc();
      chk("b_leg0_peak", leg(duty_b, 0), 200);
      run_to(2040);
      chk("a_duty_2040", duty_a, 48'h0000_0080_00C8);
      chk("a_pend_2040", pending_a, 0);

      run_to(2099);
      wr(3'd1, 8'd60);
      run_to(2295);
      chk("b_leg1_peak", leg(duty_b, 1), 60);
      chk("a_leg1_peak", leg(duty_a, 1), 0);
      chk("a_pend_leg1", pending_a, 6'b000010);
      run_to(2399);
      wr(3'd1, 8'd50);
      run_to(2549);
      chk("b_leg1_prevalley", leg(duty_b, 1), 60);
      cyc();
      chk("b_leg1_valley", leg(duty_b, 1), 50);
      chk("a_leg1_valley", leg(duty_a, 1), 50);

      run_to(2730);
      chk("carrier_180", carrier_a, 180);
      en = 1'b0;
      cyc();
      chk("dis_carrier", carrier_a, 0);
      chk("dis_duty_a", duty_a, 0);
      chk("dis_duty_b", duty_b, 0);
      chk("dis_ce", ce_a, 0);
      wr(3'd3, 8'd90);
      chk("dis_pend", pending_a, 6'b001000);
      chk("dis_carrier_hold", carrier_a, 0);
      en = 1'b1;
      cyc();
      chk("en_duty_a", duty_a, 48'h0000_5A80_32C8);
      chk("en_duty_b", duty_b, 48'h0000_5A80_32C8);
      chk("en_valley", valley_a, 1);
      chk("en_pend", pending_a, 0);
      chk("en_carrier", carrier_a, 0);
      cyc();
      chk("en_first_step", carrier_a, 1);

      divider = 8'd3;
      cyc();
      chk("div_carrier_2", carrier_a, 2);
      for (int i = 0; i < 12; i++) begin
         cyc();
         ce_got[i] = ce_a;
         if (edge_n == 2740) divider = 8'd1;
      end
      chk("div_ce_pattern", ce_got, ce_exp);
      chk("div_carrier_6", carrier_a, 6);

      wr(3'd4, 8'd11);
      chk("prerst_pend", pending_a, 6'b010000);
      #3;
      rst_n = 1'b0;
      #2;
      chk("midrst_carrier", carrier_a, 0);
      chk("midrst_duty_a", duty_a, 0);
      chk("midrst_duty_b", duty_b, 0);
      chk("midrst_pend", pending_a, 0);
      chk("midrst_pulses", {valley_a, peak_a, ce_a}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
